// File: rtl/chrisruk_strip_rx.sv
// Receive-side decoder for the LED-strip clock/data link: finds the 32-zero
// start frame and deserialises 32-bit LED words into brightness/colour fields.
module chrisruk_strip_rx #(
    parameter int unsigned NUM_LEDS = 64,
    parameter int unsigned TIMEOUT  = 4095
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sclk,
    input  logic       sdat,
    output logic       led_valid,
    output logic [5:0] led_index,
    output logic [4:0] led_bright,
    output logic [7:0] led_blue,
    output logic [7:0] led_green,
    output logic [7:0] led_red,
    output logic       frame_done,
    output logic       frame_err,
    output logic       in_frame
);

    typedef enum logic {HUNT, WORD} state_t;

    localparam logic [5:0]  LAST_IDX  = 6'(NUM_LEDS - 1);
    localparam logic [11:0] TIMEOUT_V = 12'(TIMEOUT);

    state_t      state;
    logic        sclk_s1, sclk_s2, sclk_s3;
    logic        sdat_s1, sdat_s2;
    logic [5:0]  zero_cnt;
    logic [4:0]  bit_cnt;
    logic [31:0] shreg;
    logic [5:0]  idx;
    logic [11:0] idle_cnt;
    logic        word_rdy;
    logic        sclk_edge, sclk_fall, timeout_hit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sclk_s1 <= 1'b0;
            sclk_s2 <= 1'b0;
            sclk_s3 <= 1'b0;
            sdat_s1 <= 1'b0;
            sdat_s2 <= 1'b0;
        end else begin
            sclk_s1 <= sclk;
            sclk_s2 <= sclk_s1;
            sclk_s3 <= sclk_s2;
            sdat_s1 <= sdat;
            sdat_s2 <= sdat_s1;
        end
    end

    assign sclk_edge   = sclk_s3 ^ sclk_s2;
    assign sclk_fall   = sclk_s3 & ~sclk_s2;
    // An edge in the same cycle clears the idle counter, so a 32nd bit wins over a timeout.
    assign timeout_hit = (state == WORD) && !sclk_edge && ((idle_cnt + 12'd1) == TIMEOUT_V);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= HUNT;
            zero_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            idx        <= '0;
            idle_cnt   <= '0;
            word_rdy   <= 1'b0;
            led_valid  <= 1'b0;
            led_index  <= '0;
            led_bright <= '0;
            led_blue   <= '0;
            led_green  <= '0;
            led_red    <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            in_frame   <= 1'b0;
        end else begin
            led_valid  <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            in_frame   <= (state == WORD);

            if (sclk_edge)
                idle_cnt <= '0;
            else if (idle_cnt != '1)
                idle_cnt <= idle_cnt + 12'd1;

            if (timeout_hit) begin
                frame_err <= 1'b1;
                state     <= HUNT;
                zero_cnt  <= '0;
                bit_cnt   <= '0;
                idx       <= '0;
                idle_cnt  <= '0;
                word_rdy  <= 1'b0;
            end else if (word_rdy) begin
                // The completed word is judged one cycle after its last bit lands,
                // giving the output-register stage; legal sclk rates leave no fall here.
                word_rdy <= 1'b0;
                if (shreg[31:29] == 3'b111) begin
                    led_valid  <= 1'b1;
                    led_index  <= idx;
                    led_bright <= shreg[28:24];
                    led_blue   <= shreg[23:16];
                    led_green  <= shreg[15:8];
                    led_red    <= shreg[7:0];
                    if (idx == LAST_IDX) begin
                        frame_done <= 1'b1;
                        state      <= HUNT;
                        zero_cnt   <= '0;
                        idx        <= '0;
                    end else begin
                        idx <= idx + 6'd1;
                    end
                end else begin
                    frame_err <= 1'b1;
                    state     <= HUNT;
                    zero_cnt  <= '0;
                    idx       <= '0;
                end
            end else if (sclk_fall) begin
                unique case (state)
                    HUNT: begin
                        if (!sdat_s2) begin
                            if (zero_cnt != 6'd32)
                                zero_cnt <= zero_cnt + 6'd1;
                        end else if (zero_cnt == 6'd32) begin
                            state   <= WORD;
                            shreg   <= {31'b0, 1'b1};
                            bit_cnt <= 5'd1;
                        end else begin
                            zero_cnt <= '0;
                        end
                    end
                    WORD: begin
                        shreg   <= {shreg[30:0], sdat_s2};
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd31)
                            word_rdy <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_chrisruk_strip_rx.sv
// Bench for chrisruk_strip_rx: two instances (64 and 4 LEDs) share one stimulus
// stream; a bit-stream reference model predicts every strobe and its cycle.
module tb_chrisruk_strip_rx;

    typedef struct {
        int          dut;
        int          kind;   // 0 led, 1 done, 2 err
        int          idx;
        logic [31:0] word;
        int          cyc;    // -1: cycle not predicted
    } ev_t;

    logic clk = 1'b0, reset = 1'b0, sclk = 1'b0, sdat = 1'b0;
    logic       a_valid, a_done, a_err, a_in, b_valid, b_done, b_err, b_in;
    logic [5:0] a_index, b_index;
    logic [4:0] a_bright, b_bright;
    logic [7:0] a_blue, a_green, a_red, b_blue, b_green, b_red;
    logic [38:0] a_all, b_all;

    int cyc = 0;
    int vectors = 0, miscompares = 0;
    ev_t got[$], exp_q[$];
    bit  seg_bits[$];
    int  seg_fall[$];

    chrisruk_strip_rx #(.NUM_LEDS(64), .TIMEOUT(100)) dut_a (
        .clk(clk), .reset(reset), .sclk(sclk), .sdat(sdat),
        .led_valid(a_valid), .led_index(a_index), .led_bright(a_bright),
        .led_blue(a_blue), .led_green(a_green), .led_red(a_red),
        .frame_done(a_done), .frame_err(a_err), .in_frame(a_in));

    chrisruk_strip_rx #(.NUM_LEDS(4), .TIMEOUT(100)) dut_b (
        .clk(clk), .reset(reset), .sclk(sclk), .sdat(sdat),
        .led_valid(b_valid), .led_index(b_index), .led_bright(b_bright),
        .led_blue(b_blue), .led_green(b_green), .led_red(b_red),
        .frame_done(b_done), .frame_err(b_err), .in_frame(b_in));

    assign a_all = {a_valid, a_index, a_bright, a_blue, a_green, a_red, a_done, a_err, a_in};
    assign b_all = {b_valid, b_index, b_bright, b_blue, b_green, b_red, b_done, b_err, b_in};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic ev_t mk(input int d, input int k, input int i, input logic [31:0] w, input int c);
        ev_t e;
        e.dut = d; e.kind = k; e.idx = i; e.word = w; e.cyc = c;
        return e;
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            if (a_valid) got.push_back(mk(0, 0, int'(a_index), {3'b111, a_bright, a_blue, a_green, a_red}, cyc));
            if (a_done)  got.push_back(mk(0, 1, a_valid ? int'(a_index) : 99, '0, cyc));
            if (a_err)   got.push_back(mk(0, 2, a_valid ? 99 : 0, '0, cyc));
            if (b_valid) got.push_back(mk(1, 0, int'(b_index), {3'b111, b_bright, b_blue, b_green, b_red}, cyc));
            if (b_done)  got.push_back(mk(1, 1, b_valid ? int'(b_index) : 99, '0, cyc));
            if (b_err)   got.push_back(mk(1, 2, b_valid ? 99 : 0, '0, cyc));
        end
    end

    task automatic send_bit(input bit b, input int hi, input int lo);
        @(negedge clk); sdat = b; sclk = 1'b1;
        repeat (hi - 1) @(negedge clk);
        @(negedge clk); sclk = 1'b0;
        seg_bits.push_back(b);
        seg_fall.push_back(cyc);
        repeat (lo - 1) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input int hi, input int lo);
        for (int k = 31; k >= 0; k--) send_bit(w[k], hi, lo);
    endtask

    task automatic send_zeros(input int n, input int hi, input int lo);
        for (int k = 0; k < n; k++) send_bit(1'b0, hi, lo);
    endtask

    // Scan the bit stream: a 1 after >=32 zeros opens a frame, then whole
    // 32-bit words follow until the frame completes or a header is bad.
    task automatic model_seg(input int d, input int num, input bit timeout_end);
        int zeros, idx, i, c;
        bit inw;
        logic [31:0] w;
        zeros = 0; idx = 0; i = 0; inw = 0;
        while (i < seg_bits.size()) begin
            if (!inw) begin
                if (seg_bits[i] == 1'b0) begin zeros++; i++; end
                else if (zeros >= 32) inw = 1;
                else begin zeros = 0; i++; end
            end else begin
                if (i + 32 > seg_bits.size()) break;
                w = '0;
                for (int k = 0; k < 32; k++) w = {w[30:0], seg_bits[i + k]};
                c = seg_fall[i + 31] + 4;
                if (w[31:29] == 3'b111) begin
                    exp_q.push_back(mk(d, 0, idx, w, c));
                    idx++;
                    if (idx == num) begin
                        exp_q.push_back(mk(d, 1, num - 1, '0, c));
                        inw = 0; zeros = 0; idx = 0;
                    end
                end else begin
                    exp_q.push_back(mk(d, 2, 0, '0, c));
                    inw = 0; zeros = 0; idx = 0;
                end
                i += 32;
            end
        end
        if (timeout_end && inw) exp_q.push_back(mk(d, 2, 0, '0, -1));
    endtask

    task automatic boundary(input bit timeout_end);
        model_seg(0, 64, timeout_end);
        model_seg(1, 4, timeout_end);
        seg_bits.delete();
        seg_fall.delete();
    endtask

    task automatic check_results(input string name);
        int gl[$], el[$];
        int n;
        repeat (10) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            gl.delete(); el.delete();
            foreach (got[k]) if (got[k].dut == d) gl.push_back(k);
            foreach (exp_q[k]) if (exp_q[k].dut == d) el.push_back(k);
            vectors++;
            if (gl.size() != el.size()) begin
                miscompares++;
                $display("FAIL %s dut%0d event count: got %0d expected %0d", name, d, gl.size(), el.size());
            end
            n = (gl.size() < el.size()) ? gl.size() : el.size();
            for (int k = 0; k < n; k++) begin
                ev_t g, e;
                g = got[gl[k]];
                e = exp_q[el[k]];
                vectors++;
                if (g.kind != e.kind || g.idx != e.idx || g.word !== e.word ||
                    (e.cyc >= 0 && g.cyc != e.cyc)) begin
                    miscompares++;
                    $display("FAIL %s dut%0d event %0d: got kind=%0d idx=%0d word=%h cyc=%0d expected kind=%0d idx=%0d word=%h cyc=%0d",
                             name, d, k, g.kind, g.idx, g.word, g.cyc, e.kind, e.idx, e.word, e.cyc);
                end
            end
        end
        got.delete();
        exp_q.delete();
    endtask

    task automatic apply_reset;
        @(negedge clk); reset = 1'b0; sclk = 1'b0; sdat = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        seg_bits.delete(); seg_fall.delete(); got.delete(); exp_q.delete();
    endtask

    function automatic logic [31:0] rand_word(input bit good);
        logic [31:0] w;
        w = $urandom;
        if (good) w[31:29] = 3'b111;
        return w;
    endfunction

    task automatic test_reset;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (a_all !== '0 || b_all !== '0) begin
            miscompares++;
            $display("FAIL reset_state: got a=%h b=%h expected 0", a_all, b_all);
        end
        reset = 1'b1;
        repeat (5) @(negedge clk);
        vectors++;
        if (a_all !== '0 || b_all !== '0) begin
            miscompares++;
            $display("FAIL reset_idle: got a=%h b=%h expected 0", a_all, b_all);
        end
    endtask

    task automatic test_nominal;
        apply_reset();
        send_zeros(32, 1, 1);
        for (int i = 0; i < 64; i++) begin
            send_word((i % 2 == 0) ? 32'hF00F0000 : 32'hF0000000, 1, 1);
            if (i == 10) begin
                vectors++;
                if (a_in !== 1'b1) begin
                    miscompares++;
                    $display("FAIL nominal in_frame: got %b expected 1", a_in);
                end
            end
        end
        send_zeros(64, 1, 1);
        vectors++;
        if (a_in !== 1'b0 || b_in !== 1'b0) begin
            miscompares++;
            $display("FAIL nominal in_frame after frame: got %b%b expected 00", a_in, b_in);
        end
        boundary(0);
        check_results("nominal");
    endtask

    task automatic test_header_error;
        apply_reset();
        send_zeros(32, 1, 1);
        for (int i = 0; i < 64; i++)
            send_word((i == 5) ? 32'h7F000000 : ((i % 2 == 0) ? 32'hF00F0000 : 32'hF0000000), 1, 1);
        send_zeros(64, 1, 1);
        for (int i = 0; i < 4; i++) send_word(rand_word(1), 1, 1);
        send_zeros(4, 1, 1);
        boundary(0);
        check_results("header_error");
    endtask

    task automatic test_short_start;
        apply_reset();
        send_zeros(31, 1, 1);
        send_word(32'hFF123456, 1, 1);
        send_zeros(40, 1, 1);
        send_word(32'hFF123456, 1, 1);
        send_zeros(8, 1, 1);
        boundary(0);
        check_results("short_start");
    endtask

    task automatic test_timeout;
        logic [31:0] w;
        apply_reset();
        send_zeros(32, 1, 1);
        send_word(rand_word(1), 1, 1);
        send_word(rand_word(1), 1, 1);
        w = rand_word(1);
        for (int k = 31; k > 21; k--) send_bit(w[k], 1, 1);
        repeat (4) @(negedge clk);
        vectors++;
        if (a_in !== 1'b1 || b_in !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout in_frame before: got %b%b expected 11", a_in, b_in);
        end
        repeat (150) @(negedge clk);
        vectors++;
        if (a_in !== 1'b0 || b_in !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout in_frame after: got %b%b expected 00", a_in, b_in);
        end
        boundary(1);
        check_results("timeout");
        send_zeros(32, 1, 1);
        for (int i = 0; i < 4; i++) send_word(rand_word(1), 1, 1);
        send_zeros(4, 1, 1);
        boundary(0);
        check_results("timeout_recover");
    endtask

    task automatic test_reset_mid_word;
        logic [31:0] w;
        apply_reset();
        send_zeros(32, 1, 1);
        for (int i = 0; i < 3; i++) send_word(rand_word(1), 1, 1);
        w = rand_word(1);
        for (int k = 31; k > 11; k--) send_bit(w[k], 1, 1);
        boundary(0);
        @(negedge clk); reset = 1'b0;
        #1;
        vectors++;
        if (a_all !== '0 || b_all !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_word outputs: got a=%h b=%h expected 0", a_all, b_all);
        end
        @(negedge clk); reset = 1'b1;
        check_results("reset_mid_word");
        send_zeros(32, 1, 1);
        for (int i = 0; i < 5; i++) send_word(rand_word(1), 1, 1);
        send_zeros(4, 1, 1);
        boundary(0);
        check_results("reset_recover");
    endtask

    task automatic test_slow;
        apply_reset();
        send_zeros(40, 3, 5);
        for (int i = 0; i < 4; i++) send_word(rand_word(1), 3, 5);
        send_zeros(8, 3, 5);
        boundary(0);
        check_results("slow");
    endtask

    task automatic test_random;
        int hi, lo;
        for (int it = 0; it < 6; it++) begin
            apply_reset();
            hi = $urandom_range(1, 3);
            lo = $urandom_range(1, 3);
            send_zeros($urandom_range(28, 40), hi, lo);
            repeat ($urandom_range(1, 6)) send_word(rand_word($urandom_range(0, 99) < 85), hi, lo);
            send_zeros($urandom_range(0, 40), hi, lo);
            boundary(0);
            check_results("random");
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_header_error();
        test_short_start();
        test_timeout();
        test_reset_mid_word();
        test_slow();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/chrisruk_strip_rx.md
# chrisruk_strip_rx

Receive-side decoder for the serial LED-strip link produced by the matrix driver. It samples the strip clock/data pair, finds the 32-bit zero start frame and deserialises each 32-bit LED word into brightness and colour fields with a per-LED index. It also checks the header bits, supervises link timeouts, and flags frame completion. It sits directly downstream of the matrix driver. It is used as an on-chip loopback monitor and as a bench-side strip model.

## Interface
- `NUM_LEDS`, default 64: LED words per frame, range 1..64.
- `TIMEOUT`, default 4095: clk cycles without an `sclk` edge before a mid-frame abort, range 1..4095.
- `clk` in 1: system clock. All logic is on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `sclk` in 1: strip clock from the driver.
- `sdat` in 1: strip data from the driver. It changes only on `sclk` rising edges.
- `led_valid` out 1: one-cycle strobe. The `led_*` fields are valid only when it is high.
- `led_index` out 6: LED position within the frame, 0..NUM_LEDS-1.
- `led_bright` out 5: word bits 28:24.
- `led_blue` out 8: word bits 23:16.
- `led_green` out 8: word bits 15:8.
- `led_red` out 8: word bits 7:0.
- `frame_done` out 1: one-cycle strobe, coincident with `led_valid` for index NUM_LEDS-1.
- `frame_err` out 1: one-cycle strobe on a header error or a timeout.
- `in_frame` out 1: high while in the WORD state.

## Operation
- **Input sampling**
  - `sclk` and `sdat` each pass through a 2-flop synchroniser.
  - A third `sclk` flop feeds the edge detector.
  - One bit is captured per synchronised `sclk` falling edge, MSB first.
- **States**
  - HUNT: counts consecutive 0 bits in a 6-bit counter that saturates at 32. A 1 bit resets the counter.
  - HUNT → WORD: taken when a 1 bit arrives while the counter equals 32. That bit is bit 31 of LED 0. Extra leading zeros are legal.
  - WORD: shifts bits into a 32-bit register with a 5-bit bit counter. On the 32nd bit:
    - If bits 31:29 equal 3'b111, strobe `led_valid` with fields and `led_index`, then increment the index.
    - Otherwise pulse `frame_err`, emit no `led_valid`, and go to HUNT with the zero counter cleared.
  - After index NUM_LEDS-1 is emitted, pulse `frame_done` and go to HUNT with the zero counter cleared.
  - Trailing end-frame zeros are absorbed by HUNT and count toward the next start frame.
- **Timeout**
  - A 12-bit idle counter clears on any synchronised `sclk` edge and increments otherwise.
  - In WORD, reaching TIMEOUT pulses `frame_err`, returns to HUNT, and clears all counters.
  - In HUNT, the idle counter saturates and has no effect.
- **Field hold:** `led_*` fields hold their last values between strobes.
- **Reset values:** all outputs 0, state HUNT, all counters and the shift register 0, synchroniser flops 0.
- **Reset mid-frame:** the partial word is discarded and no strobe is produced. After release, a full 32-zero start frame is required again.

## Timing
- **Input rate:** `sclk` high and low phases must each be ≥1 clk cycle. The driver's toggle-every-clk output is the fastest legal input.
- **Latency:** `led_valid` rises 4 clk cycles after the pin-level falling edge of `sclk` for bit 0 of the word.
  - 2 cycles for synchronisation.
  - 1 cycle for edge detection and capture.
  - 1 cycle for the output register.
- **Strobes:** `led_valid`, `frame_done` and `frame_err` are registered and last exactly 1 cycle.
- **Mutual exclusion:**
  - `frame_err` never coincides with `led_valid`.
  - If a timeout and a 32nd bit occur in the same cycle, the bit takes priority because an edge clears the idle counter.
- **Frame time:** minimum (32 + 32·NUM_LEDS)·2 clk cycles.
- **Index wrap:** `led_index` returns to 0 only via HUNT and never wraps inside a frame.
- **`in_frame` timing:** rises the cycle after the HUNT → WORD transition and falls the cycle after `frame_done` or `frame_err`.

## Test plan
- **Nominal frame:** NUM_LEDS=64, 32 zeros, then 64 words alternating 0xF00F0000 and 0xF0000000, then 64 zeros, at fastest `sclk`.
  - 64 `led_valid` strobes with index 0..63.
  - Even indices: bright=16, blue=0x0F, green=0, red=0.
  - Odd indices: all colour fields 0.
  - `frame_done` with index 63, no `frame_err`.
- **Header error:** as the nominal frame, but word 5 = 0x7F000000.
  - Strobes for indices 0..4, then `frame_err`.
  - No further `led_valid` until a new 32-zero start frame.
  - The next frame then restarts at index 0.
- **Short start frame:** 31 zeros, then 0xFF123456.
  - No `led_valid`.
  - With 40 zeros instead, one strobe: bright=31, blue=0x12, green=0x34, red=0x56.
- **Timeout:** TIMEOUT=100, hold `sclk` for 100 clk after 10 bits of word 2.
  - `frame_err` strobe, `in_frame` falls, no strobe for index 2.
- **Reset mid-word:** assert `reset` low for 1 cycle during bit 20 of word 3.
  - All outputs 0 immediately.
  - A fresh complete frame afterwards decodes from index 0.
- **Slow clock:** `sclk` high 3 / low 5 clk cycles, NUM_LEDS=4.
  - Same field values as at fastest rate.
  - `led_valid` exactly 4 clk after the pin falling edge of each word's last bit.
